// File: rtl/wb_burst_master.sv
// wb_burst_master
// Wishbone B3 master engine. Accepts one command (start address, direction,
// byte selects, beat count) and runs it as a classic single-beat cycle or as
// an incrementing burst with registered bus outputs. Handles wb_rty_i by
// re-issuing the beat after a one-cycle gap, fails on bus error, an exhausted
// retry budget or a stalled beat, and reports the outcome with done/error.
//
// Ports
//   wb_clk, wb_rst_n      clock, synchronous active-low reset
//   wb_adr_o..wb_bte_o    registered Wishbone master outputs
//   wb_dat_i, wb_ack_i,
//   wb_err_i, wb_rty_i    Wishbone slave responses
//   start, address, write,
//   selection, burst_len  command; taken only while busy=0
//   wr_data, wr_next      write data source handshake (wr_next is combinational)
//   rd_data, rd_valid     registered read data, one pulse per acked read beat
//   busy, done            command in progress / one-cycle end-of-command pulse
//   error, err_code       outcome, held until the next accepted command
module wb_burst_master #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BURST = 16,
    parameter int RETRY_MAX = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                         wb_clk,
    input  logic                         wb_rst_n,
    output logic [AW-1:0]                wb_adr_o,
    output logic [DW-1:0]                wb_dat_o,
    output logic [DW/8-1:0]              wb_sel_o,
    output logic                         wb_we_o,
    output logic                         wb_cyc_o,
    output logic                         wb_stb_o,
    output logic [2:0]                   wb_cti_o,
    output logic [1:0]                   wb_bte_o,
    input  logic [DW-1:0]                wb_dat_i,
    input  logic                         wb_ack_i,
    input  logic                         wb_err_i,
    input  logic                         wb_rty_i,
    input  logic                         start,
    input  logic [AW-1:0]                address,
    input  logic                         write,
    input  logic [DW/8-1:0]              selection,
    input  logic [$clog2(MAX_BURST)-1:0] burst_len,
    input  logic [DW-1:0]                wr_data,
    output logic                         wr_next,
    output logic [DW-1:0]                rd_data,
    output logic                         rd_valid,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [1:0]                   err_code
);

    localparam int SW = DW / 8;
    localparam int BW = $clog2(MAX_BURST);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [RW-1:0] RTY_LIM  = RW'(RETRY_MAX);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] CODE_BUS = 2'b01;
    localparam logic [1:0] CODE_RTY = 2'b10;
    localparam logic [1:0] CODE_TMO = 2'b11;

    typedef enum logic [1:0] {IDLE, BEAT, RTY_GAP, FIN} state_t;

    state_t        state, state_n;
    logic [BW-1:0] beat, blen;
    logic [RW-1:0] rty_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          fail;
    logic [1:0]    fail_code;
    logic          ev_err, ev_rty, ev_ack, last_beat, rty_exhausted, tmo_hit;

    // Cycle type for beat idx of a command with len+1 beats.
    function automatic logic [2:0] cti_for(input logic [BW-1:0] idx, input logic [BW-1:0] len);
        if (len == '0)
            return 3'b000;
        else if (idx == len)
            return 3'b111;
        else
            return 3'b010;
    endfunction

    // Responses only count while strobed; err outranks rty, rty outranks ack.
    assign ev_err        = wb_stb_o & wb_err_i;
    assign ev_rty        = wb_stb_o & ~wb_err_i & wb_rty_i;
    assign ev_ack        = wb_stb_o & ~wb_err_i & ~wb_rty_i & wb_ack_i;
    assign last_beat     = (beat == blen);
    assign rty_exhausted = (rty_cnt == RTY_LIM);
    assign tmo_hit       = (TIMEOUT != 0) && wb_stb_o && !wb_err_i && !wb_rty_i && !wb_ack_i
                           && (tmo_cnt == TMO_LAST);

    // An ack masked by err/rty does not consume a write word.
    assign wr_next  = ev_ack & wb_we_o & ~last_beat;
    assign busy     = (state != IDLE);
    assign done     = (state == FIN);
    assign wb_bte_o = 2'b00;

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        fail      = 1'b0;
        fail_code = 2'b00;
        case (state)
            IDLE: begin
                if (start)
                    state_n = BEAT;
            end
            BEAT: begin
                if (ev_err) begin
                    state_n   = FIN;
                    fail      = 1'b1;
                    fail_code = CODE_BUS;
                end else if (ev_rty) begin
                    if (rty_exhausted) begin
                        state_n   = FIN;
                        fail      = 1'b1;
                        fail_code = CODE_RTY;
                    end else begin
                        state_n = RTY_GAP;
                    end
                end else if (ev_ack) begin
                    if (last_beat)
                        state_n = FIN;
                end else if (tmo_hit) begin
                    state_n   = FIN;
                    fail      = 1'b1;
                    fail_code = CODE_TMO;
                end
            end
            RTY_GAP: state_n = BEAT;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cti_o <= 3'b000;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'b00;
            beat     <= '0;
            blen     <= '0;
            rty_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            rd_valid <= 1'b0;
            // cyc and stb track the beat state one edge ahead, so the retry
            // gap and the drop after the final response fall out naturally.
            wb_cyc_o <= (state_n == BEAT);
            wb_stb_o <= (state_n == BEAT);
            case (state)
                IDLE: begin
                    if (start) begin
                        wb_adr_o <= address;
                        wb_dat_o <= wr_data;
                        wb_sel_o <= selection;
                        wb_we_o  <= write;
                        wb_cti_o <= cti_for('0, burst_len);
                        blen     <= burst_len;
                        beat     <= '0;
                        rty_cnt  <= '0;
                        tmo_cnt  <= '0;
                        error    <= 1'b0;
                        err_code <= 2'b00;
                    end
                end
                BEAT: begin
                    if (fail) begin
                        error    <= 1'b1;
                        err_code <= fail_code;
                    end
                    if (ev_rty) begin
                        if (!rty_exhausted)
                            rty_cnt <= rty_cnt + RW'(1);
                        tmo_cnt <= '0;
                    end else if (ev_ack) begin
                        if (!wb_we_o) begin
                            rd_data  <= wb_dat_i;
                            rd_valid <= 1'b1;
                        end
                        if (!last_beat) begin
                            wb_adr_o <= wb_adr_o + AW'(SW);
                            wb_dat_o <= wr_data;
                            wb_cti_o <= cti_for(beat + BW'(1), blen);
                            beat     <= beat + BW'(1);
                            rty_cnt  <= '0;
                            tmo_cnt  <= '0;
                        end
                    end else if (!ev_err) begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                FIN: wb_cti_o <= 3'b000;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed table, randomized commands against a
// beat-level reference model, and hand sequences for reset and busy start.
module tb_wb_burst_master;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXB = 16;
    localparam int RMAX = 3;
    localparam int TMO  = 255;

    localparam int K_ACK  = 0;
    localparam int K_RTY  = 1;
    localparam int K_ERR  = 2;
    localparam int K_NONE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   wb_adr_o, wb_dat_o, wb_dat_i, address, wr_data, rd_data;
    logic [3:0]    wb_sel_o, selection, burst_len;
    logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o, err_code;
    logic          start, write, wr_next, rd_valid, busy, done, error;

    always #5 clk = ~clk;

    wb_burst_master #(.DW(DW), .AW(AW), .MAX_BURST(MAXB), .RETRY_MAX(RMAX), .TIMEOUT(TMO)) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .start(start), .address(address), .write(write), .selection(selection),
        .burst_len(burst_len), .wr_data(wr_data), .wr_next(wr_next),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .error(error), .err_code(err_code)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Slave script: one entry per strobed attempt, plus burst write words.
    int          s_kind [64];
    int          s_wait [64];
    logic [31:0] s_rdat [64];
    logic [31:0] words  [16];

    // Reference model results.
    logic [31:0] m_adr [64];
    logic [31:0] m_dat [64];
    logic [2:0]  m_cti [64];
    logic [31:0] m_rd  [16];
    int m_natt, m_rdn, m_code, m_wrn, m_stb, m_lat;

    // Observed results of the last command.
    int o_code, o_att, o_rd, o_wrn, o_cyc;

    // Walks the script attempt by attempt: each attempt strobes for wait+1
    // cycles (or TMO cycles if it never answers), retries cost a one-cycle gap.
    task automatic model(input logic [31:0] base, input logic we, input int blen);
        int beat, rc, gaps;
        bit fin;
        beat = 0; rc = 0; gaps = 0; fin = 0;
        m_natt = 0; m_rdn = 0; m_code = 0; m_wrn = 0; m_stb = 0;
        for (int a = 0; a < 64 && !fin; a++) begin
            m_adr[a] = base + 32'(beat * 4);
            m_dat[a] = words[beat];
            m_cti[a] = (blen == 0) ? 3'b000 : ((beat == blen) ? 3'b111 : 3'b010);
            m_natt++;
            if (s_kind[a] == K_NONE || s_wait[a] >= TMO) begin
                m_stb += TMO; m_code = 3; fin = 1;
            end else begin
                m_stb += s_wait[a] + 1;
                if (s_kind[a] == K_ERR) begin
                    m_code = 1; fin = 1;
                end else if (s_kind[a] == K_RTY) begin
                    if (rc == RMAX) begin m_code = 2; fin = 1; end
                    else begin rc++; gaps++; end
                end else begin
                    if (!we) begin m_rd[m_rdn] = s_rdat[a]; m_rdn++; end
                    if (beat == blen) fin = 1;
                    else begin
                        if (we) m_wrn++;
                        beat++; rc = 0;
                    end
                end
            end
        end
        m_lat = m_stb + gaps + 1;
    endtask

    task automatic run_cmd(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                           input int blen, input bit poke);
        int lat, att, k, wptr;
        bit in_att, got;
        model(addr, we, blen);
        @(negedge clk);
        start = 1'b1; address = addr; write = we; selection = sel;
        burst_len = 4'(blen); wr_data = words[0];
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        lat = 0; att = -1; k = 0; wptr = 0; in_att = 0; got = 0;
        o_rd = 0; o_wrn = 0; o_cyc = 0; o_code = -1;
        @(negedge clk);
        while (!got && lat < 3000) begin
            lat++;
            start = 1'b0;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
            wb_dat_i = $urandom;
            if (rd_valid) begin
                if (o_rd < m_rdn) chk("rd_data", rd_data, m_rd[o_rd]);
                o_rd++;
            end
            if (done) begin
                got = 1;
                o_code = int'(err_code);
                chk("error_at_done", 32'(error), 32'(m_code != 0));
            end else begin
                if (wb_cyc_o) o_cyc++;
                if (poke && lat == 2) begin
                    start = 1'b1; address = 32'hBAD0; burst_len = 4'd5; write = ~we;
                end
                if (wb_stb_o) begin
                    if (!in_att) begin
                        att++; in_att = 1; k = 0;
                        if (att < m_natt) begin
                            chk("beat_adr", wb_adr_o, m_adr[att]);
                            chk("beat_cti", 32'(wb_cti_o), 32'(m_cti[att]));
                            chk("beat_sel", 32'(wb_sel_o), 32'(sel));
                            chk("beat_we", 32'(wb_we_o), 32'(we));
                            chk("beat_bte", 32'(wb_bte_o), 32'(0));
                            if (we) chk("beat_dat", wb_dat_o, m_dat[att]);
                        end
                    end
                    if (att < 64 && s_kind[att] != K_NONE && k == s_wait[att]) begin
                        if (s_kind[att] == K_ACK) begin
                            wb_ack_i = 1'b1; wb_dat_i = s_rdat[att];
                        end else if (s_kind[att] == K_RTY) wb_rty_i = 1'b1;
                        else wb_err_i = 1'b1;
                        in_att = 0;
                    end else begin
                        k++;
                    end
                end else begin
                    in_att = 0;
                end
                #1;
                if (wr_next) begin
                    o_wrn++;
                    if (wptr < 15) wptr++;
                    wr_data = words[wptr];
                end
                @(negedge clk);
            end
        end
        o_att = att + 1;
        chk("done_seen", 32'(got), 32'(1));
        chk("err_code", 32'(o_code), 32'(m_code));
        chk("attempts", 32'(o_att), 32'(m_natt));
        chk("rd_count", 32'(o_rd), 32'(m_rdn));
        chk("wr_next_count", 32'(o_wrn), 32'(m_wrn));
        chk("cyc_cycles", 32'(o_cyc), 32'(m_stb));
        chk("latency", 32'(lat), 32'(m_lat));
        @(negedge clk);
        chk("done_width", 32'(done), 32'(0));
        chk("busy_after", 32'(busy), 32'(0));
        chk("error_held", 32'({error, err_code}), 32'({m_code != 0, 2'(m_code)}));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_cyc_stb"}, 32'({wb_cyc_o, wb_stb_o}), 32'(0));
        chk({tag, "_adr"}, wb_adr_o, 32'(0));
        chk({tag, "_dat"}, wb_dat_o, 32'(0));
        chk({tag, "_sel_we_cti_bte"}, 32'({wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o}), 32'(0));
        chk({tag, "_status"}, 32'({busy, done, error, err_code, rd_valid, wr_next}), 32'(0));
        chk({tag, "_rd_data"}, rd_data, 32'(0));
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        int          blen;
        int          wait_c;
        int          rty_beat;
        int          rty_n;
        int          err_beat;
        bit          hang;
        bit          poke;
        logic [31:0] rseed;
        int          e_code;
        int          e_att;
        int          e_rd;
        int          e_wrn;
        int          e_cyc;
        logic [31:0] e_last_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int n;
        int seen;
        logic [31:0] tmp;
        start = 0; address = 0; write = 0; selection = 0; burst_len = 0; wr_data = 0;
        wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;

        //         adr           we    sel   bl wt  rb rn eb hang  poke  seed           code att rd wrn cyc last
        tbl[0]  = '{32'h100,      1'b0, 4'hF, 0, 2,  -1, 0, -1, 1'b0, 1'b0, 32'hDEADBEEF, 0, 1,  1, 0, 3,   32'hDEADBEEF};
        tbl[1]  = '{32'h200,      1'b1, 4'hF, 3, 0,  -1, 0, -1, 1'b0, 1'b1, 32'h0,        0, 4,  0, 3, 4,   32'h0};
        tbl[2]  = '{32'h200,      1'b0, 4'hF, 3, 0,  1,  2, -1, 1'b0, 1'b0, 32'h11110000, 0, 6,  4, 0, 6,   32'h0};
        tbl[3]  = '{32'h400,      1'b0, 4'hF, 3, 0,  0,  4, -1, 1'b0, 1'b0, 32'h22220000, 2, 4,  0, 0, 4,   32'h0};
        tbl[4]  = '{32'h800,      1'b1, 4'hF, 7, 0,  -1, 0, 2,  1'b0, 1'b0, 32'h0,        1, 3,  0, 2, 3,   32'h0};
        tbl[5]  = '{32'h100,      1'b0, 4'hF, 0, 0,  -1, 0, -1, 1'b1, 1'b0, 32'h0,        3, 1,  0, 0, 255, 32'h0};
        tbl[6]  = '{32'h100,      1'b0, 4'hF, 0, 254,-1, 0, -1, 1'b0, 1'b0, 32'h12345678, 0, 1,  1, 0, 255, 32'h12345678};
        tbl[7]  = '{32'hFFFFFFF8, 1'b1, 4'h3, 3, 1,  -1, 0, -1, 1'b0, 1'b0, 32'h0,        0, 4,  0, 3, 8,   32'h0};
        tbl[8]  = '{32'h1000,     1'b0, 4'hC, 15,1,  -1, 0, -1, 1'b0, 1'b0, 32'h33330000, 0, 16, 16,0, 32,  32'h0};
        tbl[9]  = '{32'h40,       1'b1, 4'h1, 1, 0,  1,  1, -1, 1'b0, 1'b0, 32'h0,        0, 3,  0, 1, 3,   32'h0};
        tbl[10] = '{32'h44,       1'b1, 4'hF, 1, 3,  -1, 0, 0,  1'b0, 1'b0, 32'h0,        1, 1,  0, 0, 4,   32'h0};
        tbl[11] = '{32'h600,      1'b0, 4'hF, 2, 0,  2,  3, -1, 1'b0, 1'b0, 32'h44440000, 0, 6,  3, 0, 6,   32'h0};

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 16; j++) words[j] = 32'hA5000000 | 32'(j * 17);
            for (int a = 0; a < 64; a++) begin
                s_kind[a] = K_NONE;
                s_wait[a] = tbl[i].wait_c;
                s_rdat[a] = tbl[i].rseed ^ (32'(a) * 32'h01010101);
            end
            n = 0;
            for (int b = 0; b <= tbl[i].blen; b++) begin
                if (tbl[i].hang) break;
                if (b == tbl[i].err_beat) begin s_kind[n] = K_ERR; n++; break; end
                if (b == tbl[i].rty_beat)
                    for (int r = 0; r < tbl[i].rty_n; r++) begin s_kind[n] = K_RTY; n++; end
                s_kind[n] = K_ACK; n++;
            end
            run_cmd(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].blen, tbl[i].poke);
            chk("tbl_code", 32'(o_code), 32'(tbl[i].e_code));
            chk("tbl_attempts", 32'(o_att), 32'(tbl[i].e_att));
            chk("tbl_rd_count", 32'(o_rd), 32'(tbl[i].e_rd));
            chk("tbl_wr_next", 32'(o_wrn), 32'(tbl[i].e_wrn));
            chk("tbl_cyc", 32'(o_cyc), 32'(tbl[i].e_cyc));
            if (tbl[i].e_last_rd != 32'h0) chk("tbl_last_rd", rd_data, tbl[i].e_last_rd);
        end

        for (int c = 0; c < 40; c++) begin
            for (int j = 0; j < 16; j++) words[j] = $urandom;
            for (int a = 0; a < 64; a++) begin
                n = int'($urandom_range(0, 99));
                s_kind[a] = (n < 76) ? K_ACK : ((n < 94) ? K_RTY : K_ERR);
                s_wait[a] = int'($urandom_range(0, 3));
                s_rdat[a] = $urandom;
            end
            if ($urandom_range(0, 14) == 0) begin
                n = int'($urandom_range(0, 20));
                s_kind[n] = K_NONE;
            end
            tmp = $urandom;
            tmp[1:0] = 2'b00;
            if (c % 8 == 0) tmp = 32'hFFFFFFC0 | (tmp & 32'h3C);
            run_cmd(tmp, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), 1'b0);
        end

        // Leave error=1 behind, then reset in the middle of a write burst.
        for (int a = 0; a < 64; a++) begin s_kind[a] = K_NONE; s_wait[a] = 0; end
        s_kind[0] = K_ERR;
        run_cmd(32'h500, 1'b0, 4'hF, 3, 1'b0);
        chk("pre_reset_error", 32'(error), 32'(1));

        @(negedge clk);
        start = 1'b1; address = 32'h3000; write = 1'b1; selection = 4'hF;
        burst_len = 4'd7; wr_data = 32'hCAFE0000;
        @(negedge clk);
        start = 1'b0;
        chk("mid_cyc", 32'(wb_cyc_o), 32'(1));
        wb_ack_i = 1'b1;
        #1 wr_data = 32'hCAFE0001;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk("mid_adr", wb_adr_o, 32'h3004);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("quiet_after_reset", 32'(seen), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
